// File: rtl/midi_note_parser.sv
// MIDI channel-message byte parser: emits a one-cycle note-on strobe (key/velocity/channel), 1-cycle latency.
// Optional macro MIDI_NOTE_OFF_OUT_EN adds a note_off_valid strobe for 8n and 9n velocity-0 messages.
module midi_note_parser #(
   parameter logic [3:0] CHANNEL = 4'd9,
   parameter logic       OMNI    = 1'b0
) (
   input  logic       clk_100MHz,
   input  logic       rst_n,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       midi_valid,
   output logic [6:0] midi_key,
   output logic [6:0] midi_velocity,
   output logic [3:0] midi_channel,
   output logic [7:0] running_status
`ifdef MIDI_NOTE_OFF_OUT_EN
   ,
   output logic       note_off_valid
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DATA1 = 3'd1,
      DATA2 = 3'd2,
      SKIP  = 3'd3,
      SYSEX = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] rs_q, rs_d;
   logic [6:0] key_q, key_d;
   logic [1:0] skip_q, skip_d;
   logic       vld_q, vld_d;
   logic [6:0] okey_q, okey_d;
   logic [6:0] ovel_q, ovel_d;
   logic [3:0] ochan_q, ochan_d;
`ifdef MIDI_NOTE_OFF_OUT_EN
   logic       off_q, off_d;
`endif

   logic one_byte;
   logic chan_ok;
   logic is_note_on;

   assign one_byte   = (rs_q[7:5] == 3'b110);
   assign chan_ok    = OMNI || (rs_q[3:0] == CHANNEL);
   assign is_note_on = (rs_q[7:4] == 4'h9);

   always_comb begin
      state_d = state_q;
      rs_d    = rs_q;
      key_d   = key_q;
      skip_d  = skip_q;
      vld_d   = 1'b0;
      okey_d  = okey_q;
      ovel_d  = ovel_q;
      ochan_d = ochan_q;
`ifdef MIDI_NOTE_OFF_OUT_EN
      off_d   = 1'b0;
`endif
      if (byte_valid) begin
         if (!byte_data[7]) begin
            case (state_q)
               DATA1: begin
                  key_d   = byte_data[6:0];
                  state_d = one_byte ? DATA1 : DATA2;
               end
               DATA2: begin
                  state_d = DATA1;
                  if (chan_ok && is_note_on && (byte_data[6:0] != 7'd0)) begin
                     vld_d   = 1'b1;
                     okey_d  = key_q;
                     ovel_d  = byte_data[6:0];
                     ochan_d = rs_q[3:0];
                  end
`ifdef MIDI_NOTE_OFF_OUT_EN
                  else if (chan_ok && ((rs_q[7:4] == 4'h8) || is_note_on)) begin
                     off_d   = 1'b1;
                     okey_d  = key_q;
                     ovel_d  = byte_data[6:0];
                     ochan_d = rs_q[3:0];
                  end
`endif
               end
               SKIP: begin
                  skip_d = skip_q - 2'd1;
                  if (skip_q == 2'd1) state_d = IDLE;
               end
               default: ;
            endcase
         end else if (byte_data[7:4] != 4'hF) begin
            rs_d    = byte_data;
            state_d = DATA1;
         end else if (!byte_data[3]) begin
            // System common; real-time bytes (F8-FF) fall through untouched
            rs_d = 8'h00;
            case (byte_data[2:0])
               3'd0: state_d = SYSEX;
               3'd1, 3'd3: begin
                  state_d = SKIP;
                  skip_d  = 2'd1;
               end
               3'd2: begin
                  state_d = SKIP;
                  skip_d  = 2'd2;
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rs_q    <= 8'h00;
         key_q   <= 7'd0;
         skip_q  <= 2'd0;
         vld_q   <= 1'b0;
         okey_q  <= 7'd0;
         ovel_q  <= 7'd0;
         ochan_q <= 4'd0;
`ifdef MIDI_NOTE_OFF_OUT_EN
         off_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rs_q    <= rs_d;
         key_q   <= key_d;
         skip_q  <= skip_d;
         vld_q   <= vld_d;
         okey_q  <= okey_d;
         ovel_q  <= ovel_d;
         ochan_q <= ochan_d;
`ifdef MIDI_NOTE_OFF_OUT_EN
         off_q   <= off_d;
`endif
      end
   end

   assign midi_valid     = vld_q;
   assign midi_key       = okey_q;
   assign midi_velocity  = ovel_q;
   assign midi_channel   = ochan_q;
   assign running_status = rs_q;
`ifdef MIDI_NOTE_OFF_OUT_EN
   assign note_off_valid = off_q;
`endif

endmodule

// File: tb/tb_midi_note_parser.sv
// Directed bench for midi_note_parser: default instance (channel 9) plus an OMNI instance on the same byte stream.
module tb_midi_note_parser;

   logic       clk_100MHz;
   logic       rst_n;
   logic       byte_valid;
   logic [7:0] byte_data;

   logic       midi_valid, o_valid;
   logic [6:0] midi_key, o_key;
   logic [6:0] midi_velocity, o_vel;
   logic [3:0] midi_channel, o_chan;
   logic [7:0] running_status, o_rs;
`ifdef MIDI_NOTE_OFF_OUT_EN
   logic       note_off_valid, o_off;
`endif

   int tests = 0;
   int fails = 0;

   midi_note_parser #(.CHANNEL(4'd9), .OMNI(1'b0)) u_dut (
      .clk_100MHz     (clk_100MHz),
      .rst_n          (rst_n),
      .byte_valid     (byte_valid),
      .byte_data      (byte_data),
      .midi_valid     (midi_valid),
      .midi_key       (midi_key),
      .midi_velocity  (midi_velocity),
      .midi_channel   (midi_channel),
      .running_status (running_status)
`ifdef MIDI_NOTE_OFF_OUT_EN
      ,
      .note_off_valid (note_off_valid)
`endif
   );

   midi_note_parser #(.CHANNEL(4'd9), .OMNI(1'b1)) u_omni (
      .clk_100MHz     (clk_100MHz),
      .rst_n          (rst_n),
      .byte_valid     (byte_valid),
      .byte_data      (byte_data),
      .midi_valid     (o_valid),
      .midi_key       (o_key),
      .midi_velocity  (o_vel),
      .midi_channel   (o_chan),
      .running_status (o_rs)
`ifdef MIDI_NOTE_OFF_OUT_EN
      ,
      .note_off_valid (o_off)
`endif
   );

   always #5 clk_100MHz = ~clk_100MHz;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one byte for one cycle (back-to-back capable), then check the strobe it produced
   task automatic send(input logic [7:0] b, input logic exp_vld, input string tag);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk_100MHz);
      chk(tag, {7'd0, midi_valid}, {7'd0, exp_vld});
   endtask

   task automatic idle(input string tag);
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      @(negedge clk_100MHz);
      chk(tag, {7'd0, midi_valid}, 8'd0);
   endtask

   task automatic chk_out(input string tag, input logic [6:0] k, input logic [6:0] v,
                          input logic [3:0] c, input logic [7:0] rs);
      chk({tag, "_key"}, {1'b0, midi_key}, {1'b0, k});
      chk({tag, "_vel"}, {1'b0, midi_velocity}, {1'b0, v});
      chk({tag, "_chan"}, {4'd0, midi_channel}, {4'd0, c});
      chk({tag, "_rs"}, running_status, rs);
   endtask

   initial begin
      clk_100MHz = 1'b0;
      rst_n      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (2) @(negedge clk_100MHz);
      chk("rst_vld", {7'd0, midi_valid}, 8'd0);
      chk_out("rst", 7'd0, 7'd0, 4'd0, 8'h00);
      rst_n = 1'b1;
      @(negedge clk_100MHz);

      // Basic note-on
      send(8'h99, 1'b0, "t1_b0");
      chk("t1_rs", running_status, 8'h99);
      send(8'h24, 1'b0, "t1_b1");
      send(8'h64, 1'b1, "t1_b2");
      chk_out("t1", 7'd36, 7'd100, 4'd9, 8'h99);
`ifdef MIDI_NOTE_OFF_OUT_EN
      chk("t1_off", {7'd0, note_off_valid}, 8'd0);
`endif
      idle("t1_pulse_end");
      chk("t1_key_held", {1'b0, midi_key}, 8'd36);

      // Running status, back-to-back bytes
      send(8'h99, 1'b0, "t2_b0");
      send(8'h26, 1'b0, "t2_b1");
      send(8'h7F, 1'b1, "t2_b2");
      chk_out("t2a", 7'd38, 7'd127, 4'd9, 8'h99);
      send(8'h2E, 1'b0, "t2_b3");
      send(8'h40, 1'b1, "t2_b4");
      chk_out("t2b", 7'd46, 7'd64, 4'd9, 8'h99);
      idle("t2_end");

      // Real-time bytes interleaved mid-message
      send(8'h99, 1'b0, "t3_b0");
      send(8'h24, 1'b0, "t3_b1");
      send(8'hF8, 1'b0, "t3_f8");
      send(8'hFE, 1'b0, "t3_fe");
      chk("t3_rs_rt", running_status, 8'h99);
      send(8'h50, 1'b1, "t3_b2");
      chk_out("t3", 7'd36, 7'd80, 4'd9, 8'h99);
      idle("t3_end");

      // Channel filter vs OMNI
      send(8'h90, 1'b0, "t4_b0");
      send(8'h24, 1'b0, "t4_b1");
      send(8'h64, 1'b0, "t4_b2");
      chk_out("t4_filt", 7'd36, 7'd80, 4'd9, 8'h90);
      chk("t4_omni_vld", {7'd0, o_valid}, 8'd1);
      chk("t4_omni_key", {1'b0, o_key}, 8'd36);
      chk("t4_omni_vel", {1'b0, o_vel}, 8'd100);
      chk("t4_omni_chan", {4'd0, o_chan}, 8'd0);
      idle("t4_end");

      // Velocity zero is a note-off, never a note-on
      send(8'h99, 1'b0, "t5_b0");
      send(8'h24, 1'b0, "t5_b1");
      send(8'h00, 1'b0, "t5_b2");
`ifdef MIDI_NOTE_OFF_OUT_EN
      chk("t5_off", {7'd0, note_off_valid}, 8'd1);
      chk_out("t5", 7'd36, 7'd0, 4'd9, 8'h99);
`else
      chk_out("t5", 7'd36, 7'd80, 4'd9, 8'h99);
`endif
      idle("t5_end");

      // One-data-byte message with running status: no strobes, parsing stays aligned
      send(8'hC9, 1'b0, "t6_c9");
      send(8'h05, 1'b0, "t6_d0");
      send(8'h06, 1'b0, "t6_d1");
      chk("t6_rs", running_status, 8'hC9);

      // SysEx aborts the note and clears running status; trailing data dropped
      send(8'h99, 1'b0, "t7_b0");
      send(8'h24, 1'b0, "t7_b1");
      send(8'hF0, 1'b0, "t7_f0");
      chk("t7_rs_f0", running_status, 8'h00);
      send(8'h01, 1'b0, "t7_s0");
      send(8'h02, 1'b0, "t7_s1");
      send(8'hF7, 1'b0, "t7_f7");
      send(8'h26, 1'b0, "t7_d0");
      send(8'h40, 1'b0, "t7_d1");
      chk("t7_rs_end", running_status, 8'h00);
      idle("t7_end");

      // Song position (F2) swallows exactly two data bytes
      send(8'hF2, 1'b0, "t8_f2");
      send(8'h24, 1'b0, "t8_s0");
      send(8'h64, 1'b0, "t8_s1");
      send(8'h99, 1'b0, "t8_b0");
      send(8'h2A, 1'b0, "t8_b1");
      send(8'h33, 1'b1, "t8_b2");
      chk_out("t8", 7'd42, 7'd51, 4'd9, 8'h99);
      idle("t8_end");

      // Reset mid-message
      send(8'h99, 1'b0, "t9_b0");
      send(8'h24, 1'b0, "t9_b1");
      byte_valid = 1'b0;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk_100MHz);
      chk("t9_in_rst_vld", {7'd0, midi_valid}, 8'd0);
      chk_out("t9_in_rst", 7'd0, 7'd0, 4'd0, 8'h00);
      rst_n = 1'b1;
      send(8'h40, 1'b0, "t9_d0");
      send(8'h26, 1'b0, "t9_d1");
      send(8'h40, 1'b0, "t9_d2");
      idle("t9_idle");
      chk_out("t9_post", 7'd0, 7'd0, 4'd0, 8'h00);
      send(8'h99, 1'b0, "t9_b2");
      send(8'h26, 1'b0, "t9_b3");
      send(8'h40, 1'b1, "t9_b4");
      chk_out("t9_note", 7'd38, 7'd64, 4'd9, 8'h99);
      idle("t9_end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
